// File: rtl/tv80_reg_wb_if.sv
// tv80_reg_wb_if: write-request channel from the core datapath into the
// tv80 register write-back queue.
//   wr_valid / wr_ready : request handshake (accept = valid & ready at posedge)
//   wr_addr             : target register pair
//   wr_dh / wr_dl       : high / low byte data
//   wr_weh / wr_wel     : high / low byte write enables
// master = core datapath, slave = write-back queue.
interface tv80_reg_wb_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [7:0] wr_dh;
  logic [7:0] wr_dl;
  logic       wr_weh;
  logic       wr_wel;

  modport master (
    output wr_valid, wr_addr, wr_dh, wr_dl, wr_weh, wr_wel,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_dh, wr_dl, wr_weh, wr_wel,
    output wr_ready
  );
endinterface

// File: rtl/tv80_reg_wb.sv
// tv80_reg_wb: write-back queue in front of the tv80 register file
// (8 x 16-bit pairs, split H/L bytes, port A shared between write and read).
// Register-pair writes are buffered, retired into port A whenever the core
// does not need it, and pending bytes are checked against read ports B/C.
//
// Parameters:
//   DEPTH     queue entries, 2 or 4
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   cen                     core clock enable (to rf_cen, gates retirement)
//   wr                      write-request channel (tv80_reg_wb_if.slave)
//   rd_a_req, rd_addr_a     core claims port A for a read at rd_addr_a
//   addr_b, addr_c          read addresses of ports B and C
//   rf_dob*/rf_doc*         raw register-file read data
//   rf_addr_a, rf_dih/dil,
//   rf_weh/wel, rf_cen      register-file port A / enable
//   dob, doc                port B/C data {H,L} to the core
//   hazard_b, hazard_c      port reads a byte with a pending write
//   wb_empty, wb_count      queue status
// Configuration macro:
//   TV80_WB_BYPASS_EN       forward pending bytes onto dob/doc instead of
//                           raising hazard_b/hazard_c
module tv80_reg_wb #(
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cen,
  tv80_reg_wb_if.slave       wr,
  input  logic               rd_a_req,
  input  logic [2:0]         rd_addr_a,
  input  logic [2:0]         addr_b,
  input  logic [2:0]         addr_c,
  input  logic [7:0]         rf_dobh,
  input  logic [7:0]         rf_dobl,
  input  logic [7:0]         rf_doch,
  input  logic [7:0]         rf_docl,
  output logic [2:0]         rf_addr_a,
  output logic [7:0]         rf_dih,
  output logic [7:0]         rf_dil,
  output logic               rf_weh,
  output logic               rf_wel,
  output logic               rf_cen,
  output logic [15:0]        dob,
  output logic [15:0]        doc,
  output logic               hazard_b,
  output logic               hazard_c,
  output logic               wb_empty,
  output logic [2:0]         wb_count
);

  localparam int unsigned PW      = (DEPTH > 2) ? 2 : 1;
  localparam logic [2:0]  DEPTH_C = 3'(DEPTH);

  logic [2:0]    addr_q [DEPTH];
  logic [7:0]    dh_q   [DEPTH];
  logic [7:0]    dl_q   [DEPTH];
  logic          weh_q  [DEPTH];
  logic          wel_q  [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q,  count_d;

  logic          accept;
  logic          push;
  logic          pop;

  logic [PW-1:0] idx;
  logic          hit_bh, hit_bl, hit_ch, hit_cl;
`ifdef TV80_WB_BYPASS_EN
  logic [7:0]    fwd_bh, fwd_bl, fwd_ch, fwd_cl;
`endif

  assign wr.wr_ready = (count_q < DEPTH_C);
  assign accept      = wr.wr_valid & wr.wr_ready;
  // Requests with no byte enabled are handshaken but never stored.
  assign push        = accept & (wr.wr_weh | wr.wr_wel);
  // Retirement is suppressed during reset so discarded entries never reach
  // the register file on the reset edge.
  assign pop         = reset_n & (count_q != 3'd0) & cen & ~rd_a_req;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      addr_q[wr_ptr_q] <= wr.wr_addr;
      dh_q[wr_ptr_q]   <= wr.wr_dh;
      dl_q[wr_ptr_q]   <= wr.wr_dl;
      weh_q[wr_ptr_q]  <= wr.wr_weh;
      wel_q[wr_ptr_q]  <= wr.wr_wel;
    end
  end

  assign rf_cen    = cen;
  assign rf_addr_a = pop ? addr_q[rd_ptr_q] : rd_addr_a;
  assign rf_dih    = dh_q[rd_ptr_q];
  assign rf_dil    = dl_q[rd_ptr_q];
  assign rf_weh    = pop & weh_q[rd_ptr_q];
  assign rf_wel    = pop & wel_q[rd_ptr_q];
  assign wb_empty  = (count_q == 3'd0);
  assign wb_count  = count_q;

  // Scan occupied entries oldest to youngest; a later hit overwrites an
  // earlier one so the youngest pending write wins per byte lane. The head
  // entry is included even while it retires, as the rf is not yet updated.
  always_comb begin
    idx    = '0;
    hit_bh = 1'b0;
    hit_bl = 1'b0;
    hit_ch = 1'b0;
    hit_cl = 1'b0;
`ifdef TV80_WB_BYPASS_EN
    fwd_bh = '0;
    fwd_bl = '0;
    fwd_ch = '0;
    fwd_cl = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (i < 32'(count_q)) begin
        if (addr_q[idx] == addr_b && weh_q[idx]) begin
          hit_bh = 1'b1;
`ifdef TV80_WB_BYPASS_EN
          fwd_bh = dh_q[idx];
`endif
        end
        if (addr_q[idx] == addr_b && wel_q[idx]) begin
          hit_bl = 1'b1;
`ifdef TV80_WB_BYPASS_EN
          fwd_bl = dl_q[idx];
`endif
        end
        if (addr_q[idx] == addr_c && weh_q[idx]) begin
          hit_ch = 1'b1;
`ifdef TV80_WB_BYPASS_EN
          fwd_ch = dh_q[idx];
`endif
        end
        if (addr_q[idx] == addr_c && wel_q[idx]) begin
          hit_cl = 1'b1;
`ifdef TV80_WB_BYPASS_EN
          fwd_cl = dl_q[idx];
`endif
        end
      end
    end
  end

`ifdef TV80_WB_BYPASS_EN
  assign dob      = {hit_bh ? fwd_bh : rf_dobh, hit_bl ? fwd_bl : rf_dobl};
  assign doc      = {hit_ch ? fwd_ch : rf_doch, hit_cl ? fwd_cl : rf_docl};
  assign hazard_b = 1'b0;
  assign hazard_c = 1'b0;
`else
  assign dob      = {rf_dobh, rf_dobl};
  assign doc      = {rf_doch, rf_docl};
  assign hazard_b = hit_bh | hit_bl;
  assign hazard_c = hit_ch | hit_cl;
`endif

endmodule

// File: tb/tb_tv80_reg_wb.sv
module tb_tv80_reg_wb;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] h;
    logic [7:0] l;
    logic       eh;
    logic       el;
  } ent_t;

  logic        clk;
  logic        reset_n;
  logic        cen;
  logic        rd_a_req;
  logic [2:0]  rd_addr_a, addr_b, addr_c;
  logic [7:0]  rf_dobh, rf_dobl, rf_doch, rf_docl;
  logic [2:0]  rf_addr_a;
  logic [7:0]  rf_dih, rf_dil;
  logic        rf_weh, rf_wel, rf_cen;
  logic [15:0] dob, doc;
  logic        hazard_b, hazard_c, wb_empty;
  logic [2:0]  wb_count;

  tv80_reg_wb_if wr_if ();

  tv80_reg_wb #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .cen(cen), .wr(wr_if),
    .rd_a_req(rd_a_req), .rd_addr_a(rd_addr_a), .addr_b(addr_b), .addr_c(addr_c),
    .rf_dobh(rf_dobh), .rf_dobl(rf_dobl), .rf_doch(rf_doch), .rf_docl(rf_docl),
    .rf_addr_a(rf_addr_a), .rf_dih(rf_dih), .rf_dil(rf_dil),
    .rf_weh(rf_weh), .rf_wel(rf_wel), .rf_cen(rf_cen),
    .dob(dob), .doc(doc), .hazard_b(hazard_b), .hazard_c(hazard_c),
    .wb_empty(wb_empty), .wb_count(wb_count)
  );

  // Register file attached to the DUT, and the reference copy kept by the model.
  logic [15:0] rf_mem [8] = '{default: 16'h0};
  logic [15:0] ref_rf [8] = '{default: 16'h0};

  always @(posedge clk) begin
    if (rf_cen) begin
      if (rf_weh) rf_mem[rf_addr_a][15:8] <= rf_dih;
      if (rf_wel) rf_mem[rf_addr_a][7:0]  <= rf_dil;
    end
  end
  assign rf_dobh = rf_mem[addr_b][15:8];
  assign rf_dobl = rf_mem[addr_b][7:0];
  assign rf_doch = rf_mem[addr_c][15:8];
  assign rf_docl = rf_mem[addr_c][7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  ent_t pend[$];
  ent_t exp_q[$];

  logic [15:0] snap_dob, snap_doc;
  logic        snap_hb, snap_hc, snap_rdy;
  logic [2:0]  snap_cnt, snap_addra;
  logic [1:0]  snap_we;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Youngest pending entry per byte lane: search from the back of the queue.
  function automatic void lookup(input logic [2:0] a, output bit hh, output bit hl,
                                 output logic [7:0] dh, output logic [7:0] dl);
    hh = 0; hl = 0; dh = '0; dl = '0;
    for (int k = pend.size() - 1; k >= 0; k--) begin
      if (!hh && pend[k].a == a && pend[k].eh) begin hh = 1; dh = pend[k].h; end
      if (!hl && pend[k].a == a && pend[k].el) begin hl = 1; dl = pend[k].l; end
    end
  endfunction

  task automatic expect_port(input string nm, input logic [2:0] a,
                             input logic [15:0] act_d, input logic act_hz);
    bit hh, hl;
    logic [7:0] dh, dl;
    logic [15:0] raw;
    lookup(a, hh, hl, dh, dl);
    raw = ref_rf[a];
`ifdef TV80_WB_BYPASS_EN
    chk({nm, "_data"}, act_d, {hh ? dh : raw[15:8], hl ? dl : raw[7:0]});
    chk({nm, "_hazard"}, {15'd0, act_hz}, 16'd0);
`else
    chk({nm, "_data"}, act_d, raw);
    chk({nm, "_hazard"}, {15'd0, act_hz}, {15'd0, (hh | hl)});
`endif
  endtask

  task automatic step(input bit rn, input bit ce, input bit rq, input bit wv,
                      input logic [2:0] wa, input logic [7:0] dh, input logic [7:0] dl,
                      input bit eh, input bit el,
                      input logic [2:0] ra, input logic [2:0] ab, input logic [2:0] ac);
    int cnt;
    bit rdy, ret;
    @(negedge clk);
    reset_n = rn; cen = ce; rd_a_req = rq;
    wr_if.wr_valid = wv; wr_if.wr_addr = wa; wr_if.wr_dh = dh; wr_if.wr_dl = dl;
    wr_if.wr_weh = eh; wr_if.wr_wel = el;
    rd_addr_a = ra; addr_b = ab; addr_c = ac;
    #1;
    cnt = pend.size();
    rdy = (cnt < DEPTH);
    ret = rn && cnt > 0 && ce && !rq;
    chk("wr_ready", {15'd0, wr_if.wr_ready}, {15'd0, rdy});
    chk("wb_count", {13'd0, wb_count}, 16'(cnt));
    chk("wb_empty", {15'd0, wb_empty}, {15'd0, (cnt == 0)});
    chk("rf_cen", {15'd0, rf_cen}, {15'd0, ce});
    chk("rf_addr_a", {13'd0, rf_addr_a}, {13'd0, ret ? pend[0].a : ra});
    if (ret) exp_q.push_back(pend[0]);
    else chk("idle_we", {14'd0, rf_weh, rf_wel}, 16'd0);
    expect_port("port_b", ab, dob, hazard_b);
    expect_port("port_c", ac, doc, hazard_c);
    snap_dob = dob; snap_doc = doc; snap_hb = hazard_b; snap_hc = hazard_c;
    snap_rdy = wr_if.wr_ready; snap_cnt = wb_count; snap_addra = rf_addr_a;
    snap_we = {rf_weh, rf_wel};
    @(posedge clk);
    if (!rn) pend.delete();
    else begin
      if (ret) begin
        if (pend[0].eh) ref_rf[pend[0].a][15:8] = pend[0].h;
        if (pend[0].el) ref_rf[pend[0].a][7:0]  = pend[0].l;
        void'(pend.pop_front());
      end
      if (wv && rdy && (eh || el)) pend.push_back('{wa, dh, dl, eh, el});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 1, 0, 0, 3'd0, 8'h0, 8'h0, 0, 0, 3'd0, 3'd0, 3'd0);
  endtask

  // Retirement monitor: every rf write must be the next expected entry.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rf_weh || rf_wel) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {14'd0, rf_weh, rf_wel}, 16'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ret_addr", {13'd0, rf_addr_a}, {13'd0, e.a});
          chk("ret_data", {rf_dih, rf_dil}, {e.h, e.l});
          chk("ret_we", {14'd0, rf_weh, rf_wel}, {14'd0, e.eh, e.el});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; cen = 1; rd_a_req = 0; rd_addr_a = 0; addr_b = 0; addr_c = 0;
    wr_if.wr_valid = 0; wr_if.wr_addr = 0; wr_if.wr_dh = 0; wr_if.wr_dl = 0;
    wr_if.wr_weh = 0; wr_if.wr_wel = 0;
    repeat (2) @(posedge clk);

    // Reset state
    idle(1);
    chk("reset_count", {13'd0, snap_cnt}, 16'd0);
    chk("reset_ready", {15'd0, snap_rdy}, 16'd1);

    // Single write, retired the edge after acceptance
    step(1, 1, 0, 1, 3'd2, 8'h12, 8'h34, 1, 1, 3'd5, 3'd0, 3'd0);
    step(1, 1, 0, 0, 3'd0, 8'h00, 8'h00, 0, 0, 3'd5, 3'd2, 3'd0);
    chk("t2_addr_a", {13'd0, snap_addra}, 16'd2);
    chk("t2_we", {14'd0, snap_we}, 16'd3);
    #1;
    chk("t2_rf", rf_mem[2], 16'h1234);
    idle(1);

    // Port A busy: queue fills, third request waits, then in-order retirement
    step(1, 1, 1, 1, 3'd4, 8'hA1, 8'hB1, 1, 1, 3'd1, 3'd4, 3'd5);
    chk("t3_rdy0", {15'd0, snap_rdy}, 16'd1);
    step(1, 1, 1, 1, 3'd5, 8'hA2, 8'hB2, 1, 1, 3'd1, 3'd4, 3'd5);
    chk("t3_rdy1", {15'd0, snap_rdy}, 16'd1);
    step(1, 1, 1, 1, 3'd6, 8'hA3, 8'hB3, 1, 1, 3'd1, 3'd4, 3'd5);
    chk("t3_full", {15'd0, snap_rdy}, 16'd0);
    step(1, 1, 0, 1, 3'd6, 8'hA3, 8'hB3, 1, 1, 3'd1, 3'd5, 3'd6);
    chk("t3_head", {13'd0, snap_addra}, 16'd4);
    step(1, 1, 0, 1, 3'd6, 8'hA3, 8'hB3, 1, 1, 3'd1, 3'd5, 3'd6);
    chk("t6_cnt_before", {13'd0, snap_cnt}, 16'd1);
    idle(1);
    chk("t6_cnt_after", {13'd0, snap_cnt}, 16'd1);
    idle(2);

    // Low-byte-only pending write against rf value 5566
    step(1, 1, 0, 1, 3'd1, 8'h55, 8'h66, 1, 1, 3'd0, 3'd0, 3'd0);
    idle(2);
    step(1, 1, 1, 1, 3'd1, 8'h00, 8'hAA, 0, 1, 3'd0, 3'd0, 3'd0);
    step(1, 1, 1, 0, 3'd0, 8'h00, 8'h00, 0, 0, 3'd0, 3'd1, 3'd0);
`ifdef TV80_WB_BYPASS_EN
    chk("t4_dob", snap_dob, 16'h55AA);
    chk("t4_hazard", {15'd0, snap_hb}, 16'd0);
`else
    chk("t4_dob", snap_dob, 16'h5566);
    chk("t4_hazard", {15'd0, snap_hb}, 16'd1);
`endif
    idle(2);

    // Two pending high-byte writes to the same pair: youngest wins
    step(1, 1, 1, 1, 3'd3, 8'h11, 8'h00, 1, 0, 3'd0, 3'd0, 3'd0);
    step(1, 1, 1, 1, 3'd3, 8'h22, 8'h00, 1, 0, 3'd0, 3'd0, 3'd0);
    step(1, 1, 1, 0, 3'd0, 8'h00, 8'h00, 0, 0, 3'd0, 3'd0, 3'd3);
`ifdef TV80_WB_BYPASS_EN
    chk("t5_doc_h", {8'd0, snap_doc[15:8]}, 16'h0022);
`else
    chk("t5_hazard", {15'd0, snap_hc}, 16'd1);
`endif
    idle(2);

    // Reset with two entries pending: they never reach the rf
    step(1, 1, 1, 1, 3'd7, 8'hC1, 8'hD1, 1, 1, 3'd0, 3'd0, 3'd0);
    step(1, 1, 1, 1, 3'd7, 8'hC2, 8'hD2, 1, 1, 3'd0, 3'd0, 3'd0);
    step(0, 1, 0, 0, 3'd0, 8'h00, 8'h00, 0, 0, 3'd0, 3'd0, 3'd0);
    chk("t1_we_in_reset", {14'd0, snap_we}, 16'd0);
    idle(2);
    chk("t1_count", {13'd0, snap_cnt}, 16'd0);
    chk("t1_we", {14'd0, snap_we}, 16'd0);
    chk("t1_rf", rf_mem[7], ref_rf[7]);

    // Random traffic against the reference model
    for (int n = 0; n < 500; n++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
           3'($urandom), 8'($urandom), 8'($urandom),
           $urandom_range(0, 1), $urandom_range(0, 1),
           3'($urandom), 3'($urandom), 3'($urandom));
    end

    idle(DEPTH + 2);
    chk("drain_exp_empty", 16'(exp_q.size()), 16'd0);
    for (int r = 0; r < 8; r++) chk("final_rf", rf_mem[r], ref_rf[r]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
